beta_rf: RTL and testbench

Register-fetch/decode stage of the pipelined Beta, directly downstream of instruction fetch. Owns the IF/RF pipeline register, the 31×32 register file, operand bypassing and load-use interlock. Resolves BEQ/BNE/JMP, illegal opcodes and interrupts, and returns PCSEL, branch and jump targets to fetch in the same cycle. Registers decoded operands into the RF/ALU pipeline register.

---
 rtl/beta_rf.sv | 226 ++++++++++++++++++++++
 tb/tb_beta_rf.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beta_rf.sv
// beta_rf: register-fetch/decode stage of the pipelined Beta (IF/RF register, register file,
// operand select, interlock, branch/jump/trap resolution). Optional feature macro: BETA_BYPASS_EN.
module beta_rf (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcIn,
  input  logic [31:0] irIn,
  input  logic        irq,
  input  logic        stallIn,
  output logic        stall,
  output logic [2:0]  PCSEL,
  output logic [31:0] cRelativeA,
  output logic [31:0] jt,
  input  logic [4:0]  aluRc,
  input  logic [4:0]  memRc,
  input  logic [4:0]  wbRc,
  input  logic        aluWe,
  input  logic        memWe,
  input  logic        wbWe,
  input  logic        aluLoad,
  input  logic [31:0] aluData,
  input  logic [31:0] memData,
  input  logic [31:0] wbData,
  output logic [31:0] pcToAlu,
  output logic [31:0] irToAlu,
  output logic [31:0] aVal,
  output logic [31:0] bVal
);

  localparam logic [31:0] NOP_IR  = 32'h83FF_F800;
  localparam logic [31:0] TRAP_IR = 32'h73DF_0000;
  localparam logic [5:0]  OP_ST   = 6'h19;
  localparam logic [5:0]  OP_JMP  = 6'h1B;
  localparam logic [5:0]  OP_BEQ  = 6'h1C;
  localparam logic [5:0]  OP_BNE  = 6'h1D;
  localparam logic [5:0]  OP_LDR  = 6'h1F;
  localparam logic [4:0]  R31     = 5'd31;
  localparam logic [2:0]  PC_INC  = 3'd0;
  localparam logic [2:0]  PC_BR   = 3'd1;
  localparam logic [2:0]  PC_JMP  = 3'd2;
  localparam logic [2:0]  PC_ILL  = 3'd3;
  localparam logic [2:0]  PC_XADR = 3'd4;

  function automatic logic is_rr_op(input logic [5:0] op);
    return ((op >= 6'h20) && (op <= 6'h2A)) || ((op >= 6'h2C) && (op <= 6'h2E));
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    logic ok;
    case (op)
      6'h18, 6'h19, 6'h1B, 6'h1C, 6'h1D, 6'h1F: ok = 1'b1;
      default: ok = is_rr_op(op) || ((op >= 6'h30) && (op <= 6'h3A)) ||
                    ((op >= 6'h3C) && (op <= 6'h3E));
    endcase
    return ok;
  endfunction

  function automatic logic stage_hit(input logic we, input logic [4:0] rc, input logic [4:0] addr);
    return we && (rc == addr) && (addr != R31);
  endfunction

  logic [31:0] pc_q, pc_d, ir_q, ir_d;
  logic [31:0] pca_q, pca_d, ira_q, ira_d, a_q, a_d, b_q, b_d;
  logic [31:0] rf_q [0:30];

  logic [5:0]  op_s;
  logic [4:0]  ra_s, rb_s, rc_s, rbsel_s;
  logic [15:0] lit_s;
  logic        legal_s, use_a_s, use_b_s;
  logic [31:0] rf_a_s, rf_b_s, a_s, b_s;
  logic        il_s, stall_s, trap_s;
  logic [2:0]  pcsel_s;

  assign op_s    = ir_q[31:26];
  assign rc_s    = ir_q[25:21];
  assign ra_s    = ir_q[20:16];
  assign rb_s    = ir_q[15:11];
  assign lit_s   = ir_q[15:0];
  assign rbsel_s = (op_s == OP_ST) ? rc_s : rb_s;
  assign legal_s = is_legal_op(op_s);
  assign use_a_s = legal_s && (op_s != OP_LDR);
  assign use_b_s = is_rr_op(op_s) || (op_s == OP_ST);

  // R31 reads as zero and is never written, so it has no storage.
  assign rf_a_s = (ra_s == R31) ? 32'd0 : rf_q[ra_s];
  assign rf_b_s = (rbsel_s == R31) ? 32'd0 : rf_q[rbsel_s];

  // Register file write port, fed by the WB stage; contents are not reset.
  always_ff @(posedge clk) begin
    if (wbWe && (wbRc != R31)) begin
      rf_q[wbRc] <= wbData;
    end
  end

`ifdef BETA_BYPASS_EN
  // Operand A select, youngest producer first.
  always_comb begin
    a_s = rf_a_s;
    if (stage_hit(aluWe, aluRc, ra_s)) begin
      a_s = aluData;
    end else if (stage_hit(memWe, memRc, ra_s)) begin
      a_s = memData;
    end else if (stage_hit(wbWe, wbRc, ra_s)) begin
      a_s = wbData;
    end else begin
      a_s = rf_a_s;
    end
  end

  // Operand B select, youngest producer first.
  always_comb begin
    b_s = rf_b_s;
    if (stage_hit(aluWe, aluRc, rbsel_s)) begin
      b_s = aluData;
    end else if (stage_hit(memWe, memRc, rbsel_s)) begin
      b_s = memData;
    end else if (stage_hit(wbWe, wbRc, rbsel_s)) begin
      b_s = wbData;
    end else begin
      b_s = rf_b_s;
    end
  end

  // Only a load in ALU cannot be bypassed: its data does not exist yet.
  assign il_s = aluLoad && ((use_a_s && stage_hit(aluWe, aluRc, ra_s)) ||
                            (use_b_s && stage_hit(aluWe, aluRc, rbsel_s)));
`else
  logic unused_bypass_s;
  assign unused_bypass_s = ^{aluData, memData, aluLoad};
  assign a_s = rf_a_s;
  assign b_s = rf_b_s;

  // Without bypassing, wait until every in-flight producer has written the file.
  assign il_s = (use_a_s && (stage_hit(aluWe, aluRc, ra_s) || stage_hit(memWe, memRc, ra_s) ||
                             stage_hit(wbWe, wbRc, ra_s))) ||
                (use_b_s && (stage_hit(aluWe, aluRc, rbsel_s) || stage_hit(memWe, memRc, rbsel_s) ||
                             stage_hit(wbWe, wbRc, rbsel_s)));
`endif

  assign stall_s = stallIn || il_s;

  // Fetch redirect selection in priority order; nothing redirects while stalled or in reset.
  always_comb begin
    pcsel_s = PC_INC;
    if (reset || stall_s) begin
      pcsel_s = PC_INC;
    end else if (irq && !pc_q[31]) begin
      pcsel_s = PC_XADR;
    end else if (!legal_s) begin
      pcsel_s = PC_ILL;
    end else if (op_s == OP_JMP) begin
      pcsel_s = PC_JMP;
    end else if (((op_s == OP_BEQ) && (a_s == 32'd0)) || ((op_s == OP_BNE) && (a_s != 32'd0))) begin
      pcsel_s = PC_BR;
    end else begin
      pcsel_s = PC_INC;
    end
  end

  assign trap_s = (pcsel_s == PC_ILL) || (pcsel_s == PC_XADR);

  // Next state of both pipeline registers.
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    pca_d = pca_q;
    ira_d = ira_q;
    a_d   = a_q;
    b_d   = b_q;
    if (!stall_s) begin
      pc_d = pcIn;
      ir_d = (pcsel_s != PC_INC) ? NOP_IR : irIn;
    end else begin
      pc_d = pc_q;
      ir_d = ir_q;
    end
    if (stallIn) begin
      ira_d = ira_q;
    end else if (il_s) begin
      ira_d = NOP_IR;
      pca_d = pc_q;
      a_d   = 32'd0;
      b_d   = 32'd0;
    end else if (trap_s) begin
      // Trap becomes BEQ(R31, XADR, R30) so the ALU stage saves pcR in XP.
      ira_d = TRAP_IR;
      pca_d = pc_q;
      a_d   = 32'd0;
      b_d   = 32'd0;
    end else begin
      ira_d = ir_q;
      pca_d = pc_q;
      a_d   = a_s;
      b_d   = b_s;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= 32'd0;
      ir_q  <= NOP_IR;
      pca_q <= 32'd0;
      ira_q <= NOP_IR;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      pca_q <= pca_d;
      ira_q <= ira_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign stall      = stall_s;
  assign PCSEL      = pcsel_s;
  assign cRelativeA = pc_q + {{14{lit_s[15]}}, lit_s, 2'b00};
  assign jt         = {pc_q[31] & a_s[31], a_s[30:2], 2'b00};
  assign pcToAlu    = pca_q;
  assign irToAlu    = ira_q;
  assign aVal       = a_q;
  assign bVal       = b_q;

endmodule

// File: tb/tb_beta_rf.sv
// Self-checking bench for beta_rf: directed scenarios plus randomized traffic against a
// cycle-level reference model. Follows BETA_BYPASS_EN like the design.
module tb_beta_rf;

  logic        clk = 1'b0;
  logic        reset, irq, stallIn, stall;
  logic [31:0] pcIn, irIn, cRelativeA, jt, pcToAlu, irToAlu, aVal, bVal;
  logic [2:0]  PCSEL;
  logic [4:0]  aluRc, memRc, wbRc;
  logic        aluWe, memWe, wbWe, aluLoad;
  logic [31:0] aluData, memData, wbData;

  localparam logic [31:0] NOP  = 32'h83FF_F800;
  localparam logic [31:0] TRAP = 32'h73DF_0000;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  logic [31:0] m_pcR, m_irR, m_pcA, m_irA, m_a, m_b;
  logic [31:0] m_rf [0:30];
  logic [31:0] m_A, m_B, m_cra, m_jt;
  logic        m_il, m_stall;
  logic [2:0]  m_pcsel;

  always #5 clk = ~clk;

  beta_rf dut (
    .clk(clk), .reset(reset), .pcIn(pcIn), .irIn(irIn), .irq(irq), .stallIn(stallIn),
    .stall(stall), .PCSEL(PCSEL), .cRelativeA(cRelativeA), .jt(jt),
    .aluRc(aluRc), .memRc(memRc), .wbRc(wbRc), .aluWe(aluWe), .memWe(memWe), .wbWe(wbWe),
    .aluLoad(aluLoad), .aluData(aluData), .memData(memData), .wbData(wbData),
    .pcToAlu(pcToAlu), .irToAlu(irToAlu), .aVal(aVal), .bVal(bVal)
  );

  function automatic logic [31:0] mk_rr(input int op, input int rc, input int ra, input int rb);
    return (32'(op) << 26) | (32'(rc) << 21) | (32'(ra) << 16) | (32'(rb) << 11);
  endfunction

  function automatic logic [31:0] mk_lit(input int op, input int rc, input int ra, input int lit);
    return (32'(op) << 26) | (32'(rc) << 21) | (32'(ra) << 16) | (32'(lit) & 32'h0000_FFFF);
  endfunction

  function automatic logic legal(input logic [5:0] op);
    if (op inside {6'h18, 6'h19, 6'h1B, 6'h1C, 6'h1D, 6'h1F}) return 1'b1;
    return op[5] && (op[3:0] != 4'hB) && (op[3:0] != 4'hF);
  endfunction

  function automatic logic rr(input logic [5:0] op);
    return (op[5:4] == 2'b10) && (op[3:0] != 4'hB) && (op[3:0] != 4'hF);
  endfunction

  // value a reader would see for register addr, honouring the newest in-flight producer
  function automatic logic [31:0] operand(input logic [4:0] addr);
    if (addr == 5'd31) return 32'd0;
`ifdef BETA_BYPASS_EN
    if (aluWe && aluRc == addr) return aluData;
    if (memWe && memRc == addr) return memData;
    if (wbWe && wbRc == addr) return wbData;
`endif
    return m_rf[addr];
  endfunction

  function automatic logic pending(input logic [4:0] addr);
    if (addr == 5'd31) return 1'b0;
`ifdef BETA_BYPASS_EN
    return aluLoad && aluWe && (aluRc == addr);
`else
    return (aluWe && aluRc == addr) || (memWe && memRc == addr) || (wbWe && wbRc == addr);
`endif
  endfunction

  task automatic model_reset();
    m_pcR = 32'd0; m_irR = NOP; m_pcA = 32'd0; m_irA = NOP; m_a = 32'd0; m_b = 32'd0;
  endtask

  task automatic model_comb();
    logic [5:0] op;
    logic [4:0] ra, bad;
    logic       lg, ua, ub;
    int         off;
    op  = m_irR[31:26];
    ra  = m_irR[20:16];
    bad = (op == 6'h19) ? m_irR[25:21] : m_irR[15:11];
    lg  = legal(op);
    ua  = lg && (op != 6'h1F);
    ub  = rr(op) || (op == 6'h19);
    m_A = operand(ra);
    m_B = operand(bad);
    m_il = (ua && pending(ra)) || (ub && pending(bad));
    m_stall = stallIn || m_il;
    if (reset || m_stall) m_pcsel = 3'd0;
    else if (irq && !m_pcR[31]) m_pcsel = 3'd4;
    else if (!lg) m_pcsel = 3'd3;
    else if (op == 6'h1B) m_pcsel = 3'd2;
    else if ((op == 6'h1C && m_A == 0) || (op == 6'h1D && m_A != 0)) m_pcsel = 3'd1;
    else m_pcsel = 3'd0;
    off   = int'($signed(m_irR[15:0]));
    m_cra = m_pcR + 32'(off * 4);
    m_jt  = {m_pcR[31] & m_A[31], m_A[30:0]} & 32'hFFFF_FFFC;
  endtask

  task automatic model_clock();
    if (!stallIn) begin
      m_pcA = m_pcR;
      if (m_il) begin
        m_irA = NOP; m_a = 32'd0; m_b = 32'd0;
      end else if (m_pcsel >= 3'd3) begin
        m_irA = TRAP; m_a = 32'd0; m_b = 32'd0;
      end else begin
        m_irA = m_irR; m_a = m_A; m_b = m_B;
      end
    end
    if (!m_stall) begin
      m_irR = (m_pcsel != 3'd0) ? NOP : irIn;
      m_pcR = pcIn;
    end
    if (wbWe && wbRc != 5'd31) m_rf[wbRc] = wbData;
  endtask

  // one clock: model follows the DUT edge, returns at the next falling edge
  task automatic tick();
    model_comb();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    irIn = NOP; irq = 1'b0; stallIn = 1'b0;
    aluWe = 1'b0; memWe = 1'b0; wbWe = 1'b0; aluLoad = 1'b0;
    aluRc = 5'd0; memRc = 5'd0; wbRc = 5'd0;
    aluData = 32'd0; memData = 32'd0; wbData = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pcIn = 32'd0; idle(); model_reset();
    @(negedge clk);
    irq = 1'b1;
    #1;
    n_checks++; if (PCSEL !== 3'd0) $display("FAIL rst_pcsel: got %0d exp 0", PCSEL); else n_pass++;
    n_checks++; if (irToAlu !== NOP) $display("FAIL rst_ir: got %h exp %h", irToAlu, NOP); else n_pass++;
    n_checks++; if (pcToAlu !== 32'd0) $display("FAIL rst_pc: got %h exp 0", pcToAlu); else n_pass++;
    n_checks++; if (aVal !== 32'd0 || bVal !== 32'd0) $display("FAIL rst_ab: got %h %h exp 0 0", aVal, bVal); else n_pass++;
    @(negedge clk);
    reset = 1'b0; idle();
  endtask

  task automatic preload();
    for (int r = 0; r < 31; r++) begin
      idle(); wbWe = 1'b1; wbRc = 5'(r);
      wbData = (r == 1) ? 32'd5 : (r == 2) ? 32'd7 : (r == 5) ? 32'h8000_0123 : $urandom;
      tick();
    end
    idle();
  endtask

  task automatic test_add();
    pcIn = 32'h10; irIn = mk_rr(6'h20, 3, 1, 2);
    #1;
    n_checks++; if (PCSEL !== 3'd0) $display("FAIL add_pcsel0: got %0d exp 0", PCSEL); else n_pass++;
    tick();
    irIn = NOP; pcIn = 32'h14;
    #1;
    n_checks++; if (PCSEL !== 3'd0) $display("FAIL add_pcsel1: got %0d exp 0", PCSEL); else n_pass++;
    tick();
    n_checks++; if (irToAlu !== 32'h8061_1000) $display("FAIL add_ir: got %h exp 80611000", irToAlu); else n_pass++;
    n_checks++; if (aVal !== 32'd5) $display("FAIL add_a: got %0d exp 5", aVal); else n_pass++;
    n_checks++; if (bVal !== 32'd7) $display("FAIL add_b: got %0d exp 7", bVal); else n_pass++;
  endtask

  task automatic test_back_to_back();
    pcIn = 32'h100; irIn = mk_lit(6'h1C, 31, 31, -2);
    tick();
    pcIn = 32'h104; irIn = mk_lit(6'h1C, 31, 31, 4);
    #1;
    n_checks++; if (PCSEL !== 3'd1) $display("FAIL br_pcsel: got %0d exp 1", PCSEL); else n_pass++;
    n_checks++; if (cRelativeA !== 32'hF8) $display("FAIL br_target: got %h exp f8", cRelativeA); else n_pass++;
    tick();
    n_checks++; if (irToAlu !== 32'h73FF_FFFE || pcToAlu !== 32'h100) $display("FAIL br_pass: got %h/%h exp 73fffffe/100", irToAlu, pcToAlu); else n_pass++;
    pcIn = 32'hFC; irIn = mk_lit(6'h1C, 31, 31, 16);
    #1;
    n_checks++; if (PCSEL !== 3'd0) $display("FAIL br_slot_pcsel: got %0d exp 0", PCSEL); else n_pass++;
    tick();
    n_checks++; if (irToAlu !== NOP) $display("FAIL br_slot_annul: got %h exp %h", irToAlu, NOP); else n_pass++;
    pcIn = 32'h100; irIn = mk_rr(6'h20, 3, 1, 2);
    #1;
    n_checks++; if (PCSEL !== 3'd1 || cRelativeA !== 32'h13C) $display("FAIL br2: got %0d/%h exp 1/13c", PCSEL, cRelativeA); else n_pass++;
    tick();
    irIn = NOP;
    tick();
    n_checks++; if (irToAlu !== NOP) $display("FAIL br2_annul: got %h exp %h", irToAlu, NOP); else n_pass++;
  endtask

  task automatic test_jmp();
    pcIn = 32'h200; irIn = mk_rr(6'h1B, 31, 5, 0);
    tick();
    irIn = NOP;
    #1;
    n_checks++; if (PCSEL !== 3'd2) $display("FAIL jmp_pcsel: got %0d exp 2", PCSEL); else n_pass++;
    n_checks++; if (jt !== 32'h0000_0120) $display("FAIL jmp_jt: got %h exp 00000120", jt); else n_pass++;
    tick();
  endtask

  task automatic test_illop();
    pcIn = 32'h40; irIn = 32'd0;
    tick();
    irIn = NOP;
    #1;
    n_checks++; if (PCSEL !== 3'd3) $display("FAIL ill_pcsel: got %0d exp 3", PCSEL); else n_pass++;
    irq = 1'b1;
    #1;
    n_checks++; if (PCSEL !== 3'd4) $display("FAIL irq_pcsel: got %0d exp 4", PCSEL); else n_pass++;
    tick();
    irq = 1'b0;
    n_checks++; if (irToAlu !== TRAP || pcToAlu !== 32'h40) $display("FAIL trap_word: got %h/%h exp 73df0000/40", irToAlu, pcToAlu); else n_pass++;
  endtask

  task automatic test_load_use();
    pcIn = 32'h300; irIn = mk_rr(6'h20, 3, 4, 2);
    tick();
    irIn = NOP; aluLoad = 1'b1; aluWe = 1'b1; aluRc = 5'd4; aluData = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (stall !== 1'b1 || PCSEL !== 3'd0) $display("FAIL ld_stall: got %b/%0d exp 1/0", stall, PCSEL); else n_pass++;
    tick();
    n_checks++; if (irToAlu !== NOP) $display("FAIL ld_bubble: got %h exp %h", irToAlu, NOP); else n_pass++;
    idle(); memWe = 1'b1; memRc = 5'd4; memData = 32'h1234_5678;
`ifdef BETA_BYPASS_EN
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL ld_release: got %b exp 0", stall); else n_pass++;
`else
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL ld_mem_stall: got %b exp 1", stall); else n_pass++;
    tick();
    idle(); wbWe = 1'b1; wbRc = 5'd4; wbData = 32'h1234_5678;
    tick();
    idle();
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL ld_release: got %b exp 0", stall); else n_pass++;
`endif
    tick();
    idle();
    n_checks++; if (irToAlu !== mk_rr(6'h20, 3, 4, 2) || aVal !== 32'h1234_5678) $display("FAIL ld_value: got %h/%h exp ADD/12345678", irToAlu, aVal); else n_pass++;
  endtask

  task automatic test_wb_stall();
    pcIn = 32'h700; irIn = mk_rr(6'h20, 3, 6, 2);
    tick();
    irIn = NOP; wbWe = 1'b1; wbRc = 5'd6; wbData = 32'hCAFE_0006;
    #1;
`ifdef BETA_BYPASS_EN
    n_checks++; if (stall !== 1'b0) $display("FAIL wb_nostall: got %b exp 0", stall); else n_pass++;
`else
    n_checks++; if (stall !== 1'b1) $display("FAIL wb_stall: got %b exp 1", stall); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL wb_release: got %b exp 0", stall); else n_pass++;
`endif
    tick();
    idle();
    n_checks++; if (aVal !== 32'hCAFE_0006) $display("FAIL wb_value: got %h exp cafe0006", aVal); else n_pass++;
  endtask

  task automatic test_interlock_vs_trap();
    pcIn = 32'h500; irIn = mk_rr(6'h20, 3, 4, 2);
    tick();
    irIn = NOP; irq = 1'b1; aluLoad = 1'b1; aluWe = 1'b1; aluRc = 5'd4;
    #1;
    n_checks++; if (PCSEL !== 3'd0 || stall !== 1'b1) $display("FAIL il_wins: got %0d/%b exp 0/1", PCSEL, stall); else n_pass++;
    tick();
    idle(); irq = 1'b1;
    #1;
    n_checks++; if (PCSEL !== 3'd4) $display("FAIL il_then_trap: got %0d exp 4", PCSEL); else n_pass++;
    tick();
    idle();
    n_checks++; if (irToAlu !== TRAP || pcToAlu !== 32'h500) $display("FAIL il_trap_word: got %h/%h exp 73df0000/500", irToAlu, pcToAlu); else n_pass++;
  endtask

  task automatic test_stallin();
    pcIn = 32'h600; irIn = 32'd0;
    tick();
    irIn = NOP; stallIn = 1'b1; irq = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1 || PCSEL !== 3'd0) $display("FAIL sin_comb: got %b/%0d exp 1/0", stall, PCSEL); else n_pass++;
    tick();
    n_checks++; if (irToAlu !== NOP) $display("FAIL sin_hold: got %h exp %h", irToAlu, NOP); else n_pass++;
    idle();
    #1;
    n_checks++; if (PCSEL !== 3'd3) $display("FAIL sin_resume: got %0d exp 3", PCSEL); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [5:0] ops [15] = '{6'h18, 6'h19, 6'h1B, 6'h1C, 6'h1D, 6'h1F, 6'h20, 6'h22,
                             6'h2B, 6'h2E, 6'h30, 6'h3A, 6'h3F, 6'h00, 6'h1A};
    logic [4:0] regs [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd31};
    for (int i = 0; i < 600; i++) begin
      irIn = {ops[$urandom_range(0, 14)], regs[$urandom_range(0, 8)], regs[$urandom_range(0, 8)],
              regs[$urandom_range(0, 8)], 11'($urandom)};
      pcIn = $urandom;
      irq = ($urandom_range(0, 15) == 0);
      stallIn = ($urandom_range(0, 7) == 0);
      aluWe = $urandom_range(0, 1); memWe = $urandom_range(0, 1);
      wbWe = stallIn ? 1'b0 : 1'($urandom_range(0, 1));
      aluLoad = ($urandom_range(0, 2) == 0);
      aluRc = regs[$urandom_range(0, 8)]; memRc = regs[$urandom_range(0, 8)]; wbRc = regs[$urandom_range(0, 8)];
      aluData = $urandom; memData = $urandom; wbData = $urandom;
      #1;
      model_comb();
      n_checks++; if (stall !== m_stall) $display("FAIL rnd_stall @%0d: got %b exp %b", i, stall, m_stall); else n_pass++;
      n_checks++; if (PCSEL !== m_pcsel) $display("FAIL rnd_pcsel @%0d: got %0d exp %0d", i, PCSEL, m_pcsel); else n_pass++;
      n_checks++; if (cRelativeA !== m_cra) $display("FAIL rnd_cra @%0d: got %h exp %h", i, cRelativeA, m_cra); else n_pass++;
      n_checks++; if (jt !== m_jt) $display("FAIL rnd_jt @%0d: got %h exp %h", i, jt, m_jt); else n_pass++;
      tick();
      n_checks++; if (irToAlu !== m_irA) $display("FAIL rnd_ir @%0d: got %h exp %h", i, irToAlu, m_irA); else n_pass++;
      n_checks++; if (pcToAlu !== m_pcA) $display("FAIL rnd_pc @%0d: got %h exp %h", i, pcToAlu, m_pcA); else n_pass++;
      n_checks++; if (aVal !== m_a) $display("FAIL rnd_a @%0d: got %h exp %h", i, aVal, m_a); else n_pass++;
      n_checks++; if (bVal !== m_b) $display("FAIL rnd_b @%0d: got %h exp %h", i, bVal, m_b); else n_pass++;
    end
    idle();
  endtask

  task automatic test_async_reset();
    pcIn = 32'h900; irIn = mk_rr(6'h20, 3, 1, 2);
    tick();
    tick();
    irq = 1'b1; irIn = 32'd0;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (irToAlu !== NOP || pcToAlu !== 32'd0) $display("FAIL arst_pipe: got %h/%h exp %h/0", irToAlu, pcToAlu, NOP); else n_pass++;
    n_checks++; if (aVal !== 32'd0 || bVal !== 32'd0) $display("FAIL arst_ab: got %h/%h exp 0/0", aVal, bVal); else n_pass++;
    n_checks++; if (PCSEL !== 3'd0) $display("FAIL arst_pcsel: got %0d exp 0", PCSEL); else n_pass++;
    @(negedge clk);
    reset = 1'b0; idle(); model_reset();
    tick();
    n_checks++; if (irToAlu !== NOP || pcToAlu !== 32'd0) $display("FAIL arst_after: got %h/%h exp %h/0", irToAlu, pcToAlu, NOP); else n_pass++;
  endtask

  initial begin
    test_reset();
    preload();
    test_add();
    test_back_to_back();
    test_jmp();
    test_illop();
    test_load_use();
    test_wb_stall();
    test_interlock_vs_trap();
    test_stallin();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
